// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
//
// Groups the raster-timing signals between the timing generator and the
// stages that consume it (drawing, TMDS encoder, game logic).
//
// Signals:
//   i_en           advance enable, 0 freezes the raster
//   o_hcnt[10:0]   horizontal position, 0..H_TOTAL-1
//   o_vcnt[10:0]   vertical position, 0..V_TOTAL-1
//   o_hsync        horizontal sync at the configured polarity
//   o_vsync        vertical sync at the configured polarity
//   o_de           active-area data enable
//   o_line_start   one-cycle strobe at hcnt==0
//   o_frame_start  one-cycle strobe at hcnt==0 && vcnt==0
//   o_frame_cnt    frame counter (constant 0 unless enabled in the generator)
//
// Modports:
//   master  the timing generator (drives the raster outputs, reads i_en)
//   slave   a consumer / controller (reads the raster, drives i_en)
// -----------------------------------------------------------------------------
interface video_timing_gen_if;
  logic        i_en;
  logic [10:0] o_hcnt;
  logic [10:0] o_vcnt;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic        o_line_start;
  logic        o_frame_start;
  logic [15:0] o_frame_cnt;

  modport master (
    input  i_en,
    output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
    output o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    output i_en,
    input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
    input  o_line_start, o_frame_start, o_frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Free-running raster timing generator for the HDMI output path. The counter
// origin (0,0) is the first visible pixel of a frame; downstream drawing
// stages detect a new frame with hcnt==0 && vcnt==0.
//
// Ports:
//   clk     pixel clock
//   resetn  asynchronous, active-low reset
//   vt      video_timing_gen_if.master: i_en in, raster/sync/strobe outputs
//
// Optional feature:
//   VIDEO_TIMING_FRAME_CNT_EN  when defined, o_frame_cnt is a 16-bit wrapping
//                              counter that steps with every o_frame_start;
//                              when undefined it is tied to 0 (no flops).
//
// Every output is registered, and all decode is done on the next-state
// counter values so syncs, data enable and strobes line up with
// o_hcnt/o_vcnt in the same cycle. H_TOTAL and V_TOTAL must not exceed 2048.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  video_timing_gen_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Region bounds are 12 bits wide so a sync region ending exactly at 2048
  // does not alias to 0.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  // Registered state
  logic [10:0] hcnt_q;
  logic [10:0] vcnt_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        de_q;
  logic        line_start_q;
  logic        frame_start_q;

  // Next-state values and their decode
  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        de_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        line_start_nxt;
  logic        frame_start_nxt;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    h_wrap = (hcnt_q == H_LAST);
    v_wrap = (vcnt_q == V_LAST);

    h_nxt = h_wrap ? 11'd0 : hcnt_q + 11'd1;

    v_nxt = vcnt_q;
    if (h_wrap) begin
      v_nxt = v_wrap ? 11'd0 : vcnt_q + 11'd1;
    end
  end

  // Decode on the next position so the registered flags describe the same
  // pixel as the registered counters. v_nxt only moves on an h wrap, so
  // vsync can only change when the new hcnt is 0.
  always_comb begin
    de_nxt          = ({1'b0, h_nxt} < H_ACT_END) && ({1'b0, v_nxt} < V_ACT_END);
    hsync_nxt       = (({1'b0, h_nxt} >= H_SYNC_BEG) && ({1'b0, h_nxt} < H_SYNC_END))
                      ? HS_POL : ~HS_POL;
    vsync_nxt       = (({1'b0, v_nxt} >= V_SYNC_BEG) && ({1'b0, v_nxt} < V_SYNC_END))
                      ? VS_POL : ~VS_POL;
    line_start_nxt  = (h_nxt == 11'd0);
    frame_start_nxt = line_start_nxt && (v_nxt == 11'd0);
  end

  // Reset parks the raster on the last pixel of a frame so the first enabled
  // edge lands on (0,0) and produces a clean frame_start.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vt.i_en) begin
      hcnt_q        <= h_nxt;
      vcnt_q        <= v_nxt;
      de_q          <= de_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      line_start_q  <= line_start_nxt;
      frame_start_q <= frame_start_nxt;
    end else begin
      // Frozen: position and levels hold, strobes drop so none repeats.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vt.o_hcnt        = hcnt_q;
  assign vt.o_vcnt        = vcnt_q;
  assign vt.o_de          = de_q;
  assign vt.o_hsync       = hsync_q;
  assign vt.o_vsync       = vsync_q;
  assign vt.o_line_start  = line_start_q;
  assign vt.o_frame_start = frame_start_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  // Steps on the same edge that raises o_frame_start; wraps 65535 -> 0.
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= 16'd0;
    end else if (vt.i_en && frame_start_nxt) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vt.o_frame_cnt = frame_cnt_q;
`else
  assign vt.o_frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two generators share clk/resetn: one with the default 800x525 timing, one
// with a small 32x20 raster (active-high hsync) so whole frames fit in a short
// run. A reference model based on a linear pixel index predicts every output
// each cycle; predictions are queued when the stimulus is driven and popped
// after the clock edge for comparison.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    int ha, hfp, hsy, hbp;
    int va, vfp, vsy, vbp;
    bit hpol, vpol;
  } cfg_t;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  video_timing_gen_if d_if ();
  video_timing_gen_if s_if ();

  video_timing_gen u_def (
    .clk    (clk),
    .resetn (resetn),
    .vt     (d_if)
  );

  video_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (3),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) u_sml (
    .clk    (clk),
    .resetn (resetn),
    .vt     (s_if)
  );

  cfg_t        cd, cs;
  int          pd, ps;
  logic [15:0] fcd, fcs;
  out_t        qd[$];
  out_t        qs[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit meas = 1'b0;
  int dhs_cnt = 0, dhs_min = 9999, dhs_max = -1, dde_cnt = 0;
  int sde_cnt = 0, svs_cnt = 0, sfs_cnt = 0, last_fs = -1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input cfg_t c);
    return (c.ha + c.hfp + c.hsy + c.hbp) * (c.va + c.vfp + c.vsy + c.vbp);
  endfunction

  function automatic out_t model(input cfg_t c, input int p, input bit ok, input logic [15:0] fc);
    out_t e;
    int ht, h, v;
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    h  = p % ht;
    v  = p / ht;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.de = (h < c.ha) && (v < c.va);
    e.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsy) ? c.hpol : ~c.hpol;
    e.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsy) ? c.vpol : ~c.vpol;
    e.ls = ok && (h == 0);
    e.fs = ok && (p == 0);
    e.fc = fc;
    return e;
  endfunction

  function automatic out_t obs_d();
    out_t o;
    o.h = d_if.o_hcnt;  o.v = d_if.o_vcnt;
    o.hs = d_if.o_hsync; o.vs = d_if.o_vsync; o.de = d_if.o_de;
    o.ls = d_if.o_line_start; o.fs = d_if.o_frame_start; o.fc = d_if.o_frame_cnt;
    return o;
  endfunction

  function automatic out_t obs_s();
    out_t o;
    o.h = s_if.o_hcnt;  o.v = s_if.o_vcnt;
    o.hs = s_if.o_hsync; o.vs = s_if.o_vsync; o.de = s_if.o_de;
    o.ls = s_if.o_line_start; o.fs = s_if.o_frame_start; o.fc = s_if.o_frame_cnt;
    return o;
  endfunction

  task automatic cmp(input string who, input out_t o, input out_t e);
    check({who, ".hcnt"},        16'(o.h),  16'(e.h));
    check({who, ".vcnt"},        16'(o.v),  16'(e.v));
    check({who, ".hsync"},       16'(o.hs), 16'(e.hs));
    check({who, ".vsync"},       16'(o.vs), 16'(e.vs));
    check({who, ".de"},          16'(o.de), 16'(e.de));
    check({who, ".line_start"},  16'(o.ls), 16'(e.ls));
    check({who, ".frame_start"}, 16'(o.fs), 16'(e.fs));
    check({who, ".frame_cnt"},   o.fc,      e.fc);
  endtask

  // Predict one generator's outputs after the coming edge.
  task automatic advance(input bit en, input cfg_t c, inout int p,
                         inout logic [15:0] fc, output out_t e);
    bit ok;
    ok = en && resetn;
    if (!resetn) begin
      p  = frame_len(c) - 1;
      fc = 16'd0;
    end else if (en) begin
      p = (p + 1) % frame_len(c);
    end
    e = model(c, p, ok, fc);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    if (e.fs) begin
      fc   = fc + 16'd1;
      e.fc = fc;
    end
`endif
  endtask

  task automatic step(input bit en_d, input bit en_s);
    out_t e, o;
    d_if.i_en = en_d;
    s_if.i_en = en_s;
    advance(en_d, cd, pd, fcd, e); qd.push_back(e);
    advance(en_s, cs, ps, fcs, e); qs.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = obs_d(); e = qd.pop_front(); cmp("def", o, e);
    if (meas && o.v == 11'd0) begin
      if (o.hs == 1'b0) begin
        dhs_cnt++;
        if (int'(o.h) < dhs_min) dhs_min = int'(o.h);
        if (int'(o.h) > dhs_max) dhs_max = int'(o.h);
      end
      if (o.de) dde_cnt++;
    end
    o = obs_s(); e = qs.pop_front(); cmp("sml", o, e);
    if (meas) begin
      if (o.de) sde_cnt++;
      if (o.vs == 1'b0) svs_cnt++;
      if (o.fs) begin
        sfs_cnt++;
        if (last_fs >= 0) check("sml.fs_period", 16'(cyc - last_fs), 16'(frame_len(cs)));
        last_fs = cyc;
      end
    end
  endtask

  // Compare both generators against their reset state, without a clock edge.
  task automatic check_reset();
    pd = frame_len(cd) - 1; fcd = 16'd0;
    ps = frame_len(cs) - 1; fcs = 16'd0;
    cmp("def.rst", obs_d(), model(cd, pd, 1'b0, fcd));
    cmp("sml.rst", obs_s(), model(cs, ps, 1'b0, fcs));
  endtask

  initial begin
    cd = '{ha: 640, hfp: 16, hsy: 96, hbp: 48, va: 480, vfp: 10, vsy: 2, vbp: 33,
           hpol: 1'b0, vpol: 1'b0};
    cs = '{ha: 16, hfp: 4, hsy: 6, hbp: 6, va: 12, vfp: 2, vsy: 3, vbp: 3,
           hpol: 1'b1, vpol: 1'b0};
    resetn    = 1'b0;
    d_if.i_en = 1'b0;
    s_if.i_en = 1'b0;

    // Reset state, then release away from the clock edge.
    #12;
    check_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Three full small frames; default generator scans lines 0..2.
    meas = 1'b1;
    repeat (1920) step(1'b1, 1'b1);
    meas = 1'b0;
    check("def.hs_low_cnt", 16'(dhs_cnt), 16'd96);
    check("def.hs_low_min", 16'(dhs_min), 16'd656);
    check("def.hs_low_max", 16'(dhs_max), 16'd751);
    check("def.de_line0",   16'(dde_cnt), 16'd640);
    check("sml.de_cnt",     16'(sde_cnt), 16'(3 * 16 * 12));
    check("sml.vs_low_cnt", 16'(svs_cnt), 16'(3 * 3 * 32));
    check("sml.fs_cnt",     16'(sfs_cnt), 16'd3);

    // Land the small raster on (0,0), freeze it for 10 cycles, resume.
    step(1'b1, 1'b1);
    check("sml.origin_hv", {5'd0, s_if.o_hcnt} | {5'd0, s_if.o_vcnt}, 16'd0);
    repeat (10) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);

    // Walk to mid-frame, then pulse reset between clock edges.
    for (int i = 0; i < 700 && ps != 7 * 32 + 9; i++) step(1'b1, 1'b1);
    check("sml.pre_rst_h", 16'(s_if.o_hcnt), 16'd9);
    #2;
    resetn = 1'b0;
    #1;
    check_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b1);

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    // Preload the counter so the next frame_start must wrap it to 0.
    force u_sml.frame_cnt_q = 16'hffff;
    #1;
    release u_sml.frame_cnt_q;
    fcs = 16'hffff;
`endif
    repeat (640) step(1'b1, 1'b1);
    check("sml.frame_cnt_end", s_if.o_frame_cnt, fcs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
